// File: rtl/fetch_mem_arbiter.sv
// Arbitrates the instruction prefetch and LSU requesters onto a single tagged memory port.
// Tracks in-flight loads by tag and routes returned data back to whichever side issued the load.
module fetch_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 15,
    parameter int XLEN         = 32
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            icache_req_valid,
    input  logic [XLEN-1:0] icache_req_addr,
    output logic            icache_req_ready,
    input  logic            flush,
    output logic            icache_fill_valid,
    output logic [XLEN-1:0] icache_fill_addr,
    output logic [63:0]     icache_fill_data,

    input  logic            dmem_req_valid,
    input  logic [1:0]      dmem_req_cmd,
    input  logic [XLEN-1:0] dmem_req_addr,
    input  logic [63:0]     dmem_req_data,
    output logic            dmem_req_ready,
    output logic            dmem_resp_valid,
    output logic [63:0]     dmem_resp_data,

    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,

    output logic [3:0]      outstanding
);

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;
    localparam int         SW       = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0]   starve_q, starve_d;
    logic [15:0]     valid_q, valid_d;
    logic [15:0]     instr_q, instr_d;
    logic [15:0]     stale_q, stale_d;
    logic [XLEN-1:0] addr_q [16];
    logic [XLEN-1:0] addr_d [16];
    logic [3:0]      outstanding_q, outstanding_d;

    logic            grant_i, grant_d;
    logic            starve_at_limit;
    logic            accepted;
    logic            alloc;
    logic            ret_hit;

    // Tag 0 means "none"; tags above NUM_TAGS are never tracked.
    function automatic logic tag_ok(input logic [3:0] t);
        return (t != 4'd0) && (int'(t) <= NUM_TAGS);
    endfunction

    assign starve_at_limit = (starve_q == SW'(STARVE_LIMIT));
    assign accepted        = (mem2proc_response != 4'd0);

    // Grant: data wins ties unless the instruction side has been starved long enough.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!reset) begin
            if (dmem_req_valid && !(icache_req_valid && !flush && starve_at_limit))
                grant_d = 1'b1;
            else if (icache_req_valid && !flush)
                grant_i = 1'b1;
        end
    end

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (grant_i) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = icache_req_addr;
        end else if (grant_d) begin
            proc2mem_command = dmem_req_cmd;
            proc2mem_addr    = dmem_req_addr;
            proc2mem_data    = dmem_req_data;
        end
    end

    assign icache_req_ready = grant_i && accepted;
    assign dmem_req_ready   = grant_d && accepted;

    always_comb begin
        starve_d = '0;
        if (icache_req_valid && !grant_i)
            starve_d = starve_at_limit ? starve_q : starve_q + SW'(1);
    end

    // Return path: route data to the recorded owner; stale instruction fills are dropped.
    assign ret_hit = !reset && tag_ok(mem2proc_tag) && valid_q[mem2proc_tag];

    always_comb begin
        icache_fill_valid = 1'b0;
        icache_fill_addr  = '0;
        icache_fill_data  = '0;
        dmem_resp_valid   = 1'b0;
        dmem_resp_data    = '0;
        if (ret_hit) begin
            if (instr_q[mem2proc_tag]) begin
                if (!stale_q[mem2proc_tag]) begin
                    icache_fill_valid = 1'b1;
                    icache_fill_addr  = addr_q[mem2proc_tag];
                    icache_fill_data  = mem2proc_data;
                end
            end else begin
                dmem_resp_valid = 1'b1;
                dmem_resp_data  = mem2proc_data;
            end
        end
    end

    assign alloc = accepted && tag_ok(mem2proc_response) &&
                   (grant_i || (grant_d && dmem_req_cmd == BUS_LOAD));

    // Table update order: flush marks stale, return clears, allocation lands last.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        stale_d = stale_q;
        addr_d  = addr_q;
        if (flush)
            stale_d = stale_q | (valid_q & instr_q);
        if (ret_hit)
            valid_d[mem2proc_tag] = 1'b0;
        if (alloc) begin
            valid_d[mem2proc_response] = 1'b1;
            instr_d[mem2proc_response] = grant_i;
            stale_d[mem2proc_response] = 1'b0;
            addr_d[mem2proc_response]  = grant_i ? icache_req_addr : dmem_req_addr;
        end
        outstanding_d = '0;
        for (int i = 0; i < 16; i++)
            outstanding_d = outstanding_d + {3'b0, valid_d[i]};
    end

    always_ff @(posedge clock) begin
        instr_q <= instr_d;
        stale_q <= stale_d;
        addr_q  <= addr_d;
        if (reset) begin
            valid_q       <= '0;
            starve_q      <= '0;
            outstanding_q <= '0;
        end else begin
            valid_q       <= valid_d;
            starve_q      <= starve_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign outstanding = outstanding_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter: grant order, tag table, flush, retry and reset behaviour.
module tb_fetch_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready;
    logic        flush;
    logic        icache_fill_valid;
    logic [31:0] icache_fill_addr;
    logic [63:0] icache_fill_data;
    logic        dmem_req_valid;
    logic [1:0]  dmem_req_cmd;
    logic [31:0] dmem_req_addr;
    logic [63:0] dmem_req_data;
    logic        dmem_req_ready;
    logic        dmem_resp_valid;
    logic [63:0] dmem_resp_data;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [3:0]  outstanding;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] NONE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    fetch_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
        .icache_req_ready(icache_req_ready), .flush(flush),
        .icache_fill_valid(icache_fill_valid), .icache_fill_addr(icache_fill_addr),
        .icache_fill_data(icache_fill_data),
        .dmem_req_valid(dmem_req_valid), .dmem_req_cmd(dmem_req_cmd),
        .dmem_req_addr(dmem_req_addr), .dmem_req_data(dmem_req_data),
        .dmem_req_ready(dmem_req_ready), .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_data(dmem_resp_data),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
        .outstanding(outstanding)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        icache_req_valid  = 1'b0;
        icache_req_addr   = '0;
        flush             = 1'b0;
        dmem_req_valid    = 1'b0;
        dmem_req_cmd      = NONE;
        dmem_req_addr     = '0;
        dmem_req_data     = '0;
        mem2proc_response = '0;
        mem2proc_data     = '0;
        mem2proc_tag      = '0;
    endtask

    // Advance past the next rising edge; inputs are then changed well away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [1:0] exp_cmd [10];
        exp_cmd = '{STORE, STORE, STORE, STORE, LOAD, STORE, STORE, STORE, STORE, LOAD};

        idle();
        reset = 1'b1;
        icache_req_valid  = 1'b1;
        dmem_req_valid    = 1'b1;
        dmem_req_cmd      = LOAD;
        mem2proc_response = 4'd3;
        settle();
        chk("rst_cmd", proc2mem_command, NONE);
        chk("rst_iready", icache_req_ready, 0);
        chk("rst_dready", dmem_req_ready, 0);
        tick();
        chk("rst_outstanding", outstanding, 0);
        idle();
        reset = 1'b0;
        tick();

        // icache-only load, tag 3 returns five cycles later
        icache_req_valid  = 1'b1;
        icache_req_addr   = 32'h100;
        mem2proc_response = 4'd3;
        settle();
        chk("s1_iready", icache_req_ready, 1);
        chk("s1_cmd", proc2mem_command, LOAD);
        chk("s1_addr", proc2mem_addr, 64'h100);
        tick();
        idle();
        chk("s1_out1", outstanding, 1);
        repeat (4) tick();
        mem2proc_tag  = 4'd3;
        mem2proc_data = 64'hDEAD_BEEF_0123_4567;
        settle();
        chk("s1_fill_v", icache_fill_valid, 1);
        chk("s1_fill_a", icache_fill_addr, 64'h100);
        chk("s1_fill_d", icache_fill_data, 64'hDEAD_BEEF_0123_4567);
        chk("s1_resp_v", dmem_resp_valid, 0);
        tick();
        idle();
        chk("s1_out0", outstanding, 0);

        // both requesters continuously valid, everything accepted
        for (int i = 0; i < 10; i++) begin
            icache_req_valid  = 1'b1;
            icache_req_addr   = 32'h200;
            dmem_req_valid    = 1'b1;
            dmem_req_cmd      = STORE;
            dmem_req_addr     = 32'h280;
            dmem_req_data     = 64'h55;
            mem2proc_response = 4'd1;
            settle();
            chk($sformatf("s2_cmd%0d", i), proc2mem_command, exp_cmd[i]);
            chk($sformatf("s2_iready%0d", i), icache_req_ready, exp_cmd[i] == LOAD);
            tick();
        end
        idle();
        chk("s2_out", outstanding, 1);
        mem2proc_tag = 4'd1;
        settle();
        chk("s2_fill_a", icache_fill_addr, 64'h200);
        tick();
        idle();
        chk("s2_out0", outstanding, 0);

        // flush after an accepted instruction load makes its fill stale
        icache_req_valid  = 1'b1;
        icache_req_addr   = 32'h300;
        mem2proc_response = 4'd2;
        tick();
        idle();
        flush             = 1'b1;
        icache_req_valid  = 1'b1;
        icache_req_addr   = 32'h340;
        mem2proc_response = 4'd9;
        settle();
        chk("s3_flush_iready", icache_req_ready, 0);
        chk("s3_flush_cmd", proc2mem_command, NONE);
        tick();
        idle();
        chk("s3_out1", outstanding, 1);
        mem2proc_tag  = 4'd2;
        mem2proc_data = 64'h1234;
        settle();
        chk("s3_fill_v", icache_fill_valid, 0);
        chk("s3_resp_v", dmem_resp_valid, 0);
        tick();
        idle();
        chk("s3_out0", outstanding, 0);

        // data load rejected three times, then accepted with tag 5
        for (int i = 0; i < 4; i++) begin
            dmem_req_valid    = 1'b1;
            dmem_req_cmd      = LOAD;
            dmem_req_addr     = 32'h400;
            mem2proc_response = (i < 3) ? 4'd0 : 4'd5;
            settle();
            chk($sformatf("s4_dready%0d", i), dmem_req_ready, i == 3);
            chk($sformatf("s4_cmd%0d", i), proc2mem_command, LOAD);
            tick();
        end
        idle();
        chk("s4_out1", outstanding, 1);
        mem2proc_tag  = 4'd5;
        mem2proc_data = 64'hCAFE_0000_0000_0005;
        settle();
        chk("s4_resp_v", dmem_resp_valid, 1);
        chk("s4_resp_d", dmem_resp_data, 64'hCAFE_0000_0000_0005);
        chk("s4_fill_v", icache_fill_valid, 0);
        tick();
        idle();
        chk("s4_out0", outstanding, 0);

        // tag 7 returns to the data side while instruction side reallocates tag 7
        dmem_req_valid    = 1'b1;
        dmem_req_cmd      = LOAD;
        dmem_req_addr     = 32'h500;
        mem2proc_response = 4'd7;
        tick();
        idle();
        icache_req_valid  = 1'b1;
        icache_req_addr   = 32'h600;
        mem2proc_response = 4'd7;
        mem2proc_tag      = 4'd7;
        mem2proc_data     = 64'h77;
        settle();
        chk("s5_resp_v", dmem_resp_valid, 1);
        chk("s5_resp_d", dmem_resp_data, 64'h77);
        chk("s5_fill_v", icache_fill_valid, 0);
        chk("s5_iready", icache_req_ready, 1);
        tick();
        idle();
        chk("s5_out", outstanding, 1);
        mem2proc_tag  = 4'd7;
        mem2proc_data = 64'h78;
        settle();
        chk("s5_fill_v2", icache_fill_valid, 1);
        chk("s5_fill_a2", icache_fill_addr, 64'h600);
        tick();
        idle();
        chk("s5_out0", outstanding, 0);

        // store allocates nothing, its tag return is ignored
        dmem_req_valid    = 1'b1;
        dmem_req_cmd      = STORE;
        dmem_req_addr     = 32'h700;
        dmem_req_data     = 64'hABCD;
        mem2proc_response = 4'd4;
        settle();
        chk("s6_dready", dmem_req_ready, 1);
        chk("s6_cmd", proc2mem_command, STORE);
        chk("s6_data", proc2mem_data, 64'hABCD);
        tick();
        idle();
        chk("s6_out", outstanding, 0);
        mem2proc_tag = 4'd4;
        settle();
        chk("s6_fill_v", icache_fill_valid, 0);
        chk("s6_resp_v", dmem_resp_valid, 0);
        tick();
        idle();
        chk("s6_out2", outstanding, 0);

        // reset mid-flight discards the entry
        icache_req_valid  = 1'b1;
        icache_req_addr   = 32'h800;
        mem2proc_response = 4'd6;
        tick();
        idle();
        chk("s7_out1", outstanding, 1);
        reset             = 1'b1;
        dmem_req_valid    = 1'b1;
        dmem_req_cmd      = LOAD;
        mem2proc_response = 4'd8;
        settle();
        chk("s7_rst_cmd", proc2mem_command, NONE);
        tick();
        idle();
        reset = 1'b0;
        chk("s7_out0", outstanding, 0);
        mem2proc_tag = 4'd6;
        settle();
        chk("s7_fill_v", icache_fill_valid, 0);
        tick();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
